// File: rtl/bfis_ctrl_pkg.sv
// bfis_ctrl_pkg: shared state type, default sizes and command word layout for the BFIS query controller
package bfis_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, DRAIN} state_t;

    localparam int DEFAULT_DIM   = 4;
    localparam int DEFAULT_K_MAX = 8;
    localparam int K_WORD_IDX    = DEFAULT_DIM + 1;

    // The k word follows the vertex word and the DIM query words.
    function automatic int k_word_idx(input int dim);
        return dim + 1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: first-word fall-through FIFO holding engine results until the host pops them
module result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr, count;
    logic full, do_wr, do_rd;

    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[IW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bfis_query_ctrl.sv
// bfis_query_ctrl: loads a search command, launches the engine, buffers its results and reports status
module bfis_query_ctrl
    import bfis_ctrl_pkg::*;
#(
    parameter int DIM            = DEFAULT_DIM,
    parameter int K_MAX          = DEFAULT_K_MAX,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [31:0]       cmd_word_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    output logic              eng_rst_out,
    output logic [31:0]       eng_vertex_id_out,
    output logic [DIM*32-1:0] eng_query_out,
    output logic [15:0]       eng_k_out,
    input  logic [31:0]       eng_result_in,
    input  logic              eng_valid_in,
    output logic [31:0]       res_data_out,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              timeout_out,
    output logic              err_out
);
    localparam int CW = $clog2(K_MAX) + 1;
    localparam int WW = $clog2(DIM + 2) + 1;
    localparam logic [WW-1:0] KIDX  = WW'(k_word_idx(DIM));
    localparam logic [15:0]   K_LIM = 16'(K_MAX);
    localparam logic [31:0]   TMO   = 32'(TIMEOUT_CYCLES);

    state_t state, state_nx;
    logic [WW-1:0] widx;
    logic [CW-1:0] cnt;
    logic [31:0] idle;
    logic [15:0] k_val;
    logic accept, k_word, push, cnt_hit, idle_hit, fifo_empty;

    assign accept   = cmd_valid_in && cmd_ready_out;
    assign k_word   = accept && state == LOAD && widx == KIDX;
    assign k_val    = cmd_word_in[15:0];
    assign push     = eng_valid_in && state == RUN;
    assign cnt_hit  = push && (16'(cnt) + 16'd1 == eng_k_out);
    assign idle_hit = state == RUN && !eng_valid_in && (idle + 32'd1 == TMO);

    assign res_valid_out = !fifo_empty;
    assign busy_out      = state == LAUNCH || state == RUN || state == DRAIN;
    assign done_out      = state == DRAIN && fifo_empty;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LOAD : IDLE;
            LOAD:    state_nx = k_word ? (k_val == 16'd0 ? IDLE : LAUNCH) : LOAD;
            LAUNCH:  state_nx = RUN;
            RUN:     state_nx = (cnt_hit || idle_hit) ? DRAIN : RUN;
            DRAIN:   state_nx = fifo_empty ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nx;
    end

    // Engine stays in reset while we are in reset; launch is a registered one-cycle pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            eng_rst_out       <= 1'b1;
            cmd_ready_out     <= 1'b0;
            widx              <= '0;
            cnt               <= '0;
            idle              <= '0;
            eng_vertex_id_out <= '0;
            eng_query_out     <= '0;
            eng_k_out         <= '0;
            timeout_out       <= 1'b0;
            err_out           <= 1'b0;
        end else begin
            eng_rst_out   <= state_nx == LAUNCH;
            cmd_ready_out <= state_nx == IDLE || state_nx == LOAD;
            if (accept && state == IDLE) begin
                eng_vertex_id_out <= cmd_word_in;
                widx              <= WW'(1);
                err_out           <= 1'b0;
                timeout_out       <= 1'b0;
            end
            if (accept && state == LOAD) begin
                for (int i = 0; i < DIM; i++)
                    if (widx == WW'(i + 1)) eng_query_out[i*32 +: 32] <= cmd_word_in;
                widx <= widx + 1'b1;
            end
            if (k_word) begin
                eng_k_out <= (k_val > K_LIM) ? K_LIM : k_val;
                err_out   <= (k_val == 16'd0) || (k_val > K_LIM);
            end
            if (state == LAUNCH) begin
                cnt  <= '0;
                idle <= '0;
            end
            if (push) cnt <= cnt + 1'b1;
            if (state == RUN) idle <= eng_valid_in ? '0 : idle + 32'd1;
            if (idle_hit) timeout_out <= 1'b1;
        end
    end

    result_fifo #(
        .DATA_WIDTH(32),
        .DEPTH     (K_MAX)
    ) u_fifo (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .wr_en  (push),
        .wr_data(eng_result_in),
        .rd_en  (res_ready_in),
        .rd_data(res_data_out),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_bfis_query_ctrl.sv
// tb_bfis_query_ctrl: table-driven and randomized checks of the query controller against a queue-based model
module tb_bfis_query_ctrl;
    localparam int DIM   = 4;
    localparam int K_MAX = 8;
    localparam int TMO   = 100;

    logic              clk_100mhz = 1'b0;
    logic              rst_n_in;
    logic [31:0]       cmd_word_in;
    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic              eng_rst_out;
    logic [31:0]       eng_vertex_id_out;
    logic [DIM*32-1:0] eng_query_out;
    logic [15:0]       eng_k_out;
    logic [31:0]       eng_result_in;
    logic              eng_valid_in;
    logic [31:0]       res_data_out;
    logic              res_valid_out;
    logic              res_ready_in;
    logic              busy_out, done_out, timeout_out, err_out;

    always #5 clk_100mhz = ~clk_100mhz;

    bfis_query_ctrl #(.DIM(DIM), .K_MAX(K_MAX), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in           (clk_100mhz),
        .rst_n_in         (rst_n_in),
        .cmd_word_in      (cmd_word_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_ready_out    (cmd_ready_out),
        .eng_rst_out      (eng_rst_out),
        .eng_vertex_id_out(eng_vertex_id_out),
        .eng_query_out    (eng_query_out),
        .eng_k_out        (eng_k_out),
        .eng_result_in    (eng_result_in),
        .eng_valid_in     (eng_valid_in),
        .res_data_out     (res_data_out),
        .res_valid_out    (res_valid_out),
        .res_ready_in     (res_ready_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .timeout_out      (timeout_out),
        .err_out          (err_out)
    );

    typedef struct {
        logic [31:0] vid;
        logic [15:0] k;
        int          n_emit;
        int          mode;
        logic [15:0] exp_k;
        bit          exp_err;
        bit          exp_launch;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[6];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=wait_expired expected=event", name);
    endfunction

    function automatic logic [31:0] qword(input logic [31:0] vid, input int j);
        if (vid == 32'd1) return (j == 0) ? 32'd5 : (j == 1) ? 32'd7 : 32'd1;
        return vid * 32'd16 + 32'(j);
    endfunction

    function automatic logic [31:0] rval(input logic [31:0] vid, input int i);
        return 32'(10 * (i + 1)) + 32'd1000 * (vid - 32'd1);
    endfunction

    // Consumer side: every pop must match the model queue head.
    initial forever begin
        @(negedge clk_100mhz);
        if (rst_n_in && res_valid_out && res_ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%0h expected=none", res_data_out);
            end else check("res_data", res_data_out, exp_q.pop_front());
        end
        if (done_out) done_cnt++;
    end

    initial begin
        res_ready_in = 1'b0;
        forever begin
            @(posedge clk_100mhz);
            #1;
            case (ready_mode)
                0:       res_ready_in = 1'b1;
                1:       res_ready_in = 1'b0;
                2:       res_ready_in = ~res_ready_in;
                default: res_ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 0;
        cmd_word_in  = w;
        cmd_valid_in = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = cmd_ready_out;
            tick();
        end
        cmd_valid_in = 1'b0;
        if (!ok) expired("cmd_ready_wait");
    endtask

    task automatic load(input logic [31:0] vid, input logic [15:0] k);
        send_word(vid);
        for (int j = 0; j < DIM; j++) send_word(qword(vid, j));
        send_word({16'hA5A5, k});
    endtask

    task automatic expect_launch(input logic [31:0] vid, input logic [15:0] exp_k, input bit exp_err, input bit exp_launch);
        logic [DIM*32-1:0] eq;
        for (int j = 0; j < DIM; j++) eq[j*32 +: 32] = qword(vid, j);
        check("err_after_k", err_out, exp_err);
        if (!exp_launch) begin
            check("k0_cmd_ready", cmd_ready_out, 1'b1);
            check("k0_busy", busy_out, 1'b0);
            for (int c = 0; c < 3; c++) begin
                check("k0_no_launch", eng_rst_out, 1'b0);
                tick();
            end
            return;
        end
        check("launch_pulse", eng_rst_out, 1'b1);
        check("eng_k", eng_k_out, exp_k);
        check("eng_vertex", eng_vertex_id_out, vid);
        check("eng_query", eq, eng_query_out);
        tick();
        check("launch_one_cycle", eng_rst_out, 1'b0);
        check("busy_run", busy_out, 1'b1);
    endtask

    task automatic emit(input logic [31:0] vid, input int first, input int n, input int exp_k, input int gap_max);
        for (int i = first; i < first + n; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            eng_result_in = rval(vid, i);
            eng_valid_in  = 1'b1;
            if (i < exp_k) exp_q.push_back(rval(vid, i));
            tick();
            eng_valid_in  = 1'b0;
            eng_result_in = $urandom;
        end
    endtask

    task automatic finish_query(input bit exp_tmo, input bit exp_err, input int start);
        for (int t = 0; t < 300 && done_cnt == start; t++) tick();
        if (done_cnt == start) expired("done_wait");
        tick();
        tick();
        check("done_pulses", 32'(done_cnt), 32'(start + 1));
        check("idle_after_done", busy_out, 1'b0);
        check("results_left", 32'(exp_q.size()), 32'd0);
        check("timeout_flag", timeout_out, exp_tmo);
        check("err_flag", err_out, exp_err);
    endtask

    task automatic do_query(input logic [31:0] vid, input logic [15:0] k, input int n_emit, input int gap, input int mode,
                            input logic [15:0] exp_k, input bit exp_err, input bit exp_launch);
        int start = done_cnt;
        ready_mode = mode;
        load(vid, k);
        expect_launch(vid, exp_k, exp_err, exp_launch);
        if (exp_launch) begin
            emit(vid, 0, n_emit, int'(exp_k), gap);
            finish_query(1'b0, exp_err, start);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int start, keff, m;
        logic [15:0] k;
        vecs[0] = '{32'd1, 16'd4,  4,  0, 16'd4, 1'b0, 1'b1};
        vecs[1] = '{32'd2, 16'd0,  0,  0, 16'd0, 1'b1, 1'b0};
        vecs[2] = '{32'd3, 16'd12, 10, 3, 16'd8, 1'b1, 1'b1};
        vecs[3] = '{32'd4, 16'd8,  8,  2, 16'd8, 1'b0, 1'b1};
        vecs[4] = '{32'd5, 16'd1,  3,  0, 16'd1, 1'b0, 1'b1};
        vecs[5] = '{32'd6, 16'd9,  9,  3, 16'd8, 1'b1, 1'b1};

        rst_n_in = 1'b0;
        cmd_word_in = '0;
        cmd_valid_in = 1'b0;
        eng_result_in = '0;
        eng_valid_in = 1'b0;
        #12;
        check("rst_eng_rst", eng_rst_out, 1'b1);
        check("rst_cmd_ready", cmd_ready_out, 1'b0);
        check("rst_res_valid", res_valid_out, 1'b0);
        check("rst_res_data", res_data_out, 32'd0);
        check("rst_flags", {busy_out, done_out, timeout_out, err_out}, 4'd0);
        check("rst_eng_cfg", {eng_vertex_id_out, eng_k_out}, 48'd0);
        rst_n_in = 1'b1;
        tick();
        check("release_eng_rst", eng_rst_out, 1'b0);
        check("release_cmd_ready", cmd_ready_out, 1'b1);

        foreach (vecs[i])
            do_query(vecs[i].vid, vecs[i].k, vecs[i].n_emit, 1, vecs[i].mode,
                     vecs[i].exp_k, vecs[i].exp_err, vecs[i].exp_launch);

        // Buffer four results, then drain on alternate cycles while two more arrive.
        ready_mode = 1;
        start = done_cnt;
        load(32'd40, 16'd6);
        expect_launch(32'd40, 16'd6, 1'b0, 1'b1);
        emit(32'd40, 0, 4, 6, 0);
        check("held_valid", res_valid_out, 1'b1);
        ready_mode = 2;
        emit(32'd40, 4, 2, 6, 0);
        finish_query(1'b0, 1'b0, start);

        ready_mode = 0;
        start = done_cnt;
        load(32'd30, 16'd4);
        expect_launch(32'd30, 16'd4, 1'b0, 1'b1);
        emit(32'd30, 0, 2, 4, 0);
        repeat (TMO - 1) tick();
        check("timeout_early", timeout_out, 1'b0);
        check("busy_before_timeout", busy_out, 1'b1);
        tick();
        check("timeout_at_limit", timeout_out, 1'b1);
        finish_query(1'b1, 1'b0, start);

        // Reset in the middle of RUN with results still buffered.
        ready_mode = 1;
        load(32'd7, 16'd12);
        expect_launch(32'd7, 16'd8, 1'b1, 1'b1);
        emit(32'd7, 0, 2, 8, 0);
        check("pre_reset_valid", res_valid_out, 1'b1);
        #3 rst_n_in = 1'b0;
        #1;
        exp_q.delete();
        check("midrun_res_valid", res_valid_out, 1'b0);
        check("midrun_eng_rst", eng_rst_out, 1'b1);
        check("midrun_flags", {busy_out, done_out, timeout_out, err_out, cmd_ready_out}, 5'd0);
        check("midrun_eng_k", eng_k_out, 16'd0);
        repeat (2) @(posedge clk_100mhz);
        #2 rst_n_in = 1'b1;
        check("held_eng_rst", eng_rst_out, 1'b1);
        tick();
        check("rerelease_eng_rst", eng_rst_out, 1'b0);
        check("rerelease_res_valid", res_valid_out, 1'b0);

        ready_mode = 0;
        send_word(32'd8);
        send_word(qword(32'd8, 0));
        send_word(qword(32'd8, 1));
        #2 rst_n_in = 1'b0;
        #1 check("partial_cmd_ready", cmd_ready_out, 1'b0);
        @(posedge clk_100mhz);
        #2 rst_n_in = 1'b1;
        tick();
        do_query(32'd9, 16'd3, 3, 1, 0, 16'd3, 1'b0, 1'b1);

        for (int it = 0; it < 10; it++) begin
            k = 16'($urandom_range(0, K_MAX + 4));
            keff = (k == 0) ? 0 : (k > K_MAX) ? K_MAX : int'(k);
            m = $urandom_range(0, 2);
            do_query(32'(100 + it), k, keff + $urandom_range(0, 2), 3, (m == 0) ? 0 : m + 1,
                     16'(keff), (k == 0) || (k > K_MAX), k != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
